spine_port: RTL and testbench

SPINE_PORT -- requirements
Module: spine_port

---
 rtl/spine_pkg.sv | 7 +
 rtl/spine_sync_fifo.sv | 38 +++
 rtl/spine_port.sv | 66 ++++++
 tb/tb_spine_port.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// spine_pkg: shared widths, destination field position and output-register states
package spine_pkg;
   localparam int DWIDTH   = 16;
   localparam int DEST_MSB = 15;
   localparam int DEST_LSB = 10;
   typedef enum logic {OUT_IDLE = 1'b0, OUT_VALID = 1'b1} out_state_t;
endpackage

// File: rtl/spine_sync_fifo.sv
// spine_sync_fifo: power-of-two synchronous FIFO with combinational head read
module spine_sync_fifo #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [4:0]        count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] FULL_CNT = 5'(DEPTH);
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   assign rdata = mem[rd_ptr];
   assign full  = count == FULL_CNT;
   assign empty = count == '0;
   // storage write; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   // pointer and occupancy bookkeeping
   always_ff @(posedge clk)
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + 5'(push) - 5'(pop);
      end
endmodule

// File: rtl/spine_port.sv
// spine_port: buffered spine egress port with drop accounting and an output register
module spine_port
   import spine_pkg::*;
#(
   parameter int         DWIDTH   = spine_pkg::DWIDTH,
   parameter int         DEPTH    = 8,
   parameter logic [3:0] GROUP_ID = 4'b0010
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_valid,
   input  logic              flush,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   output logic [5:0]        out_dest_addr,
   input  logic              out_ready,
   output logic [4:0]        fifo_count,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [7:0]        drop_count,
   output logic              overflow
);
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || DWIDTH <= DEST_MSB || $bits(GROUP_ID) != 4) begin : g_bad_params
      $error("spine_port: unsupported DEPTH or DWIDTH");
   end
   out_state_t        state;
   logic [DWIDTH-1:0] fifo_rdata;
   logic              push, pop, drop;
   assign pop  = !flush && !fifo_empty && (state == OUT_IDLE || out_ready);
   assign push = !flush && in_valid && (!fifo_full || pop);
   assign drop = !flush && in_valid && fifo_full && !pop;
   assign out_valid     = state == OUT_VALID;
   assign out_dest_addr = out_data[DEST_MSB:DEST_LSB];
   spine_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   // output register: load on pop, release when the consumer takes the last flit
   always_ff @(posedge clk)
      if (reset) begin
         state    <= OUT_IDLE;
         out_data <= '0;
      end else if (flush) state <= OUT_IDLE;
      else if (pop) begin
         out_data <= fifo_rdata;
         state    <= OUT_VALID;
      end else if (out_ready) state <= OUT_IDLE;
   // saturating drop counter with sticky overflow; flush leaves both alone
   always_ff @(posedge clk)
      if (reset) begin
         drop_count <= '0;
         overflow   <= 1'b0;
      end else if (drop) begin
         drop_count <= drop_count == 8'hFF ? drop_count : drop_count + 1'b1;
         overflow   <= 1'b1;
      end
endmodule

// File: tb/tb_spine_port.sv
// tb_spine_port: directed and random stimulus checked against a queue-based port model
module tb_spine_port;
   localparam int DEPTH = 8;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic [5:0]  out_dest_addr;
   logic        out_ready = 1'b0;
   logic [4:0]  fifo_count;
   logic        fifo_full, fifo_empty;
   logic [7:0]  drop_count;
   logic        overflow;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] q[$];
   logic        m_ov = 1'b0;
   logic [15:0] m_od = '0;
   int          m_dc = 0;
   logic        m_of = 1'b0;

   spine_port #(.DWIDTH(16), .DEPTH(DEPTH), .GROUP_ID(4'b0010)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .flush         (flush),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_dest_addr (out_dest_addr),
      .out_ready     (out_ready),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .drop_count    (drop_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic step(input logic iv, input logic [15:0] id, input logic rdy, input logic fl, input logic rs);
      logic take, keep;
      in_valid = iv; in_data = id; out_ready = rdy; flush = fl; reset = rs;
      @(posedge clk);
      if (rs) begin
         q.delete(); m_ov = 1'b0; m_od = '0; m_dc = 0; m_of = 1'b0;
      end else if (fl) begin
         q.delete(); m_ov = 1'b0;
      end else begin
         take = q.size() > 0 && (!m_ov || rdy);
         keep = iv && (q.size() < DEPTH || take);
         if (take) begin
            m_od = q.pop_front(); m_ov = 1'b1;
         end else if (m_ov && rdy) m_ov = 1'b0;
         if (keep) q.push_back(id);
         else if (iv) begin
            if (m_dc < 255) m_dc++;
            m_of = 1'b1;
         end
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_dest_addr", 32'(out_dest_addr), 32'(m_od[15:10]));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("drop_count", 32'(drop_count), 32'(m_dc));
      chk("overflow", 32'(overflow), 32'(m_of));
   endtask

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_empty", 32'(fifo_empty), 32'd1);
      step(0, 0, 0, 0, 0);
      // single flit latency
      step(1, 16'hA403, 1, 0, 0);
      chk("single_not_yet", 32'(out_valid), 32'd0);
      step(0, 0, 1, 0, 0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_dest", 32'(out_dest_addr), 32'h29);
      step(0, 0, 1, 0, 0);
      chk("single_gone", 32'(out_valid), 32'd0);
      // backpressure
      step(1, 16'h0401, 0, 0, 0);
      step(1, 16'h0402, 0, 0, 0);
      step(1, 16'h0403, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("bp_hold", 32'(out_data), 32'h0401);
      chk("bp_count", 32'(fifo_count), 32'd2);
      step(0, 0, 1, 0, 0);
      chk("bp_2nd", 32'(out_data), 32'h0402);
      step(0, 0, 1, 0, 0);
      chk("bp_3rd", 32'(out_data), 32'h0403);
      step(0, 0, 1, 0, 0);
      chk("bp_done", 32'(out_valid), 32'd0);
      // overflow with ten flits
      for (int i = 0; i < 10; i++) step(1, 16'h1000 + 16'(i), 0, 0, 0);
      chk("ovf_count", 32'(fifo_count), 32'd8);
      chk("ovf_full", 32'(fifo_full), 32'd1);
      chk("ovf_drops", 32'(drop_count), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      // full with a simultaneous pop
      step(1, 16'h2222, 1, 0, 0);
      chk("fullpop_count", 32'(fifo_count), 32'd8);
      chk("fullpop_drops", 32'(drop_count), 32'd1);
      // flush with queued flits, then reset
      step(1, 16'h3333, 1, 1, 0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_count", 32'(fifo_count), 32'd0);
      chk("flush_drops", 32'(drop_count), 32'd1);
      for (int i = 0; i < 5; i++) step(1, 16'h4000 + 16'(i), 0, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("flush5_count", 32'(fifo_count), 32'd0);
      step(0, 0, 0, 0, 1);
      chk("rst_drops", 32'(drop_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      // saturation
      for (int i = 0; i < 9 + 300; i++) step(1, 16'($urandom), 0, 0, 0);
      chk("sat_drops", 32'(drop_count), 32'd255);
      step(0, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
